// File: rtl/nios_system_sysid_checker_if.sv
// Avalon-MM read-only bus between the sysid checker and the sysid slave.
// The checker is the master; the slave supplies stall and read data.
interface nios_system_sysid_checker_if;
  logic        av_address;
  logic        av_read;
  logic        av_waitrequest;
  logic [31:0] av_readdata;

  modport master (
    output av_address,
    output av_read,
    input  av_waitrequest,
    input  av_readdata
  );

  modport slave (
    input  av_address,
    input  av_read,
    output av_waitrequest,
    output av_readdata
  );
endinterface

// File: rtl/nios_system_sysid_checker.sv
// Reads the sysid slave (ID at word 0, timestamp at word 1) and compares
// both words against the expected build values, with a per-read stall limit.
module nios_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS = 32'h5041_3E0B,
  parameter int unsigned TIMEOUT     = 255,
  parameter bit          AUTO_START  = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  nios_system_sysid_checker_if.master av,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [1:0] {
    IDLE, RD_ID, RD_TS, DONE
  } state_e;

  localparam logic [15:0] STALL_MAX = 16'(TIMEOUT);

  state_e      state_q, state_d;
  logic [15:0] stall_q, stall_d;
  logic        auto_q, auto_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        tmo_q, tmo_d;

  logic rd, ack, stalled, expire, launch;

  assign rd      = (state_q == RD_ID) || (state_q == RD_TS);
  assign ack     = rd && !av.av_waitrequest;
  assign stalled = rd && av.av_waitrequest;
  assign expire  = stalled && (stall_q == STALL_MAX);
  assign launch  = ((state_q == IDLE) || (state_q == DONE))
                   && (start || auto_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      stall_q    <= '0;
      auto_q     <= AUTO_START;
      id_value_q <= '0;
      ts_value_q <= '0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      stall_q    <= stall_d;
      auto_q     <= auto_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (launch) state_d = RD_ID;
      RD_ID: begin
        if (ack)         state_d = RD_TS;
        else if (expire) state_d = DONE;
      end
      RD_TS: if (ack || expire) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // A timed-out read leaves its word and ok flag at the cleared value.
  always_comb begin
    stall_d    = stall_q;
    auto_d     = auto_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    tmo_d      = tmo_q;
    if (launch) begin
      auto_d     = 1'b0;
      stall_d    = '0;
      id_value_d = '0;
      ts_value_d = '0;
      id_ok_d    = 1'b0;
      ts_ok_d    = 1'b0;
      tmo_d      = 1'b0;
    end else if (ack) begin
      stall_d = '0;
      if (state_q == RD_ID) begin
        id_value_d = av.av_readdata;
        id_ok_d    = (av.av_readdata == EXPECTED_ID);
      end else begin
        ts_value_d = av.av_readdata;
        ts_ok_d    = (av.av_readdata == EXPECTED_TS);
      end
    end else if (expire) begin
      tmo_d = 1'b1;
    end else if (stalled) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_comb begin
    av.av_read    = rd;
    av.av_address = (state_q == RD_TS);
    busy          = rd;
    done          = (state_q == DONE);
    pass          = done && id_ok_q && ts_ok_q && !tmo_q;
    id_ok         = id_ok_q;
    ts_ok         = ts_ok_q;
    timeout_err   = tmo_q;
    id_value      = id_value_q;
    ts_value      = ts_value_q;
  end

endmodule
